// File: rtl/showcase_delay_ram.sv
// showcase_delay_ram: delayed access pipeline into a read-first RAM with compare flags, sticky flag and saturating write counter
module showcase_delay_ram #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2,
  parameter int DELAY   = 2,
  parameter int CMP_VAL = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vld,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              e,
  input  logic              clr,
  output logic              f,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_lt,
  output logic              rd_eq,
  output logic              rd_gt,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic              wr_sat
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] CMP = DATA_W'(CMP_VAL);
  logic              p_vld  [DELAY];
  logic [ADDR_W-1:0] p_addr [DELAY];
  logic              p_wr   [DELAY];
  logic [DATA_W-1:0] p_data [DELAY];
  logic [DATA_W-1:0] mem    [DEPTH];
  logic [DATA_W-1:0] mem_q;
  logic              do_acc;
  logic              do_wr;
  logic [CNT_W-1:0]  cnt_nxt;
  assign do_acc  = p_vld[DELAY-1];
  assign do_wr   = do_acc & p_wr[DELAY-1];
  assign mem_q   = mem[p_addr[DELAY-1]];
  assign cnt_nxt = (do_wr && !(&wr_cnt)) ? wr_cnt + CNT_W'(1) : wr_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DELAY; s++) begin
        p_vld[s]  <= 1'b0;
        p_addr[s] <= '0;
        p_wr[s]   <= 1'b0;
        p_data[s] <= '0;
      end
    end else begin
      p_vld[0]  <= i_vld;
      p_addr[0] <= i_addr;
      p_wr[0]   <= i_wr;
      p_data[0] <= i_data;
      for (int s = 1; s < DELAY; s++) begin
        p_vld[s]  <= p_vld[s-1];
        p_addr[s] <= p_addr[s-1];
        p_wr[s]   <= p_wr[s-1];
        p_data[s] <= p_data[s-1];
      end
    end
  end
  // RAM is deliberately unreset; the rst guard keeps a dropped access from landing
  always_ff @(posedge clk) begin
    if (do_wr && !rst) mem[p_addr[DELAY-1]] <= p_data[DELAY-1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f       <= 1'b0;
      rd_vld  <= 1'b0;
      rd_data <= '0;
      rd_lt   <= 1'b0;
      rd_eq   <= 1'b0;
      rd_gt   <= 1'b0;
      wr_cnt  <= '0;
      wr_sat  <= 1'b0;
    end else begin
      f      <= clr ? 1'b0 : (f | e);
      rd_vld <= do_acc;
      if (do_acc) begin
        rd_data <= mem_q;
        rd_lt   <= mem_q < CMP;
        rd_eq   <= mem_q == CMP;
        rd_gt   <= mem_q > CMP;
      end
      wr_cnt <= cnt_nxt;
      wr_sat <= &cnt_nxt;
    end
  end
endmodule
